demux16_dispatcher: RTL and testbench
=====================================

DEMUX16_DISPATCHER -- requirements
Module: demux16_dispatcher

Interface
REQ-001 SHALL have parameter DATA_W, default 64, the payload width.
REQ-002 SHALL have parameter TIMEOUT, default 255, the stall cycles after which a held word is dropped (range 1..255).
REQ-003 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port io_in_valid, input, 1, upstream word valid.
REQ-006 SHALL have port io_in_ready, output, 1, dispatcher can accept a word.
REQ-007 SHALL have port io_in_data, input, DATA_W, upstream payload.
REQ-008 SHALL have port io_in_dest, input, 4, destination lane in directed mode.
REQ-009 SHALL have port io_mode, input, 1: 0 = directed (use io_in_dest), 1 = round-robin.
REQ-010 SHALL have ports io_outputs_0..io_outputs_15, output, DATA_W each, the lane payloads.
REQ-011 SHALL have port io_out_valid, output, 16, one-hot lane valid.
REQ-012 SHALL have port io_out_ready, input, 16, per-lane downstream ready.
REQ-013 SHALL have port io_drop_count, output, 16, saturating count of timed-out words.
REQ-014 SHALL have port io_busy, output, 1, high while a word is held.

Function
REQ-015 SHALL implement FSM states IDLE (holding register empty) and HOLD (holding register full).
REQ-016 io_in_ready SHALL be 1 in IDLE, and in HOLD only when the selected lane's io_out_ready is 1 in the same cycle.
REQ-017 A word SHALL be captured when io_in_valid && io_in_ready; the capture stores data, the lane, and resets the stall counter to 0.
REQ-018 The lane SHALL be io_in_dest when io_mode=0, else the rr pointer; io_mode is sampled only at capture.
REQ-019 The rr pointer SHALL advance by 1 (wrap 15->0) on each round-robin capture only; directed captures leave it unchanged.
REQ-020 Transitions: IDLE->HOLD on capture; HOLD->IDLE on delivery without capture; HOLD->HOLD on delivery with capture (back-to-back, 1 word/cycle); HOLD->IDLE on timeout.
REQ-021 Delivery SHALL occur when in HOLD and io_out_ready[lane]=1.
REQ-022 In HOLD, io_out_valid SHALL be one-hot at the lane and io_outputs_<lane> SHALL equal the held data; all other lanes SHALL be 0. In IDLE all lanes and io_out_valid SHALL be 0.
REQ-023 Latency SHALL be 1 cycle: a word captured at edge N is presented from cycle N+1.
REQ-024 In HOLD without delivery, the stall counter SHALL increment; when it reaches TIMEOUT, the word SHALL be discarded at that edge, io_drop_count SHALL increment, and the FSM SHALL enter IDLE; no capture occurs in that cycle.
REQ-025 io_drop_count SHALL saturate at 16'hFFFF.
REQ-026 Delivery in the same cycle the counter would reach TIMEOUT SHALL take precedence: no drop.
REQ-027 io_busy SHALL be 1 exactly in HOLD.

Reset
REQ-028 On reset, the FSM SHALL go to IDLE, the rr pointer, stall counter and io_drop_count SHALL go to 0, and any held word SHALL be discarded without delivery.
REQ-029 During reset, io_in_ready SHALL be 0; from the first cycle after reset deasserts, all outputs SHALL hold their IDLE values (io_in_ready=1).

Structure
REQ-030 The shared package SHALL hold the FSM state enum (IDLE, HOLD), the lane count 16, and the lane index width 4.
REQ-031 The lane fan-out SHALL be one instance of the existing sub-module Demultiplexer, fed by the held data and a select that is forced to a zeroed input when in IDLE.

Verification
REQ-032 Directed: mode=0, dest=5, data=64'hDEAD_BEEF, ready=16'hFFFF -> io_outputs_5=DEAD_BEEF and io_out_valid=16'h0020 one cycle later; delivered; IDLE.
REQ-033 Back-to-back: 4 words on consecutive cycles, mode=1, all ready -> lanes 0,1,2,3 each valid for one cycle, io_in_ready stays 1.
REQ-034 Wrap: 17 round-robin words -> lanes 0..15 then 0.
REQ-035 Timeout: TIMEOUT=8, dest=3, io_out_ready[3]=0 -> drop at stall count 8, io_drop_count=1, IDLE; ready rising in that same cycle -> delivered, count stays 0.
REQ-036 Reset mid-HOLD: word held on lane 7, reset pulsed -> io_out_valid=0, drop count 0, rr pointer 0; lane 7 never sees valid with ready.

Source files
------------

// File: rtl/demux16_dispatcher_pkg.sv
// Shared types and constants for the 16-lane dispatcher.
package demux16_dispatcher_pkg;

  localparam int unsigned LANE_COUNT = 16;
  localparam int unsigned LANE_W     = 4;

  // Holding register empty (IDLE) or full (HOLD).
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/demux16_dispatcher_demultiplexer.sv
// Demultiplexer: routes one payload to a single lane, all other lanes zero.
module Demultiplexer
  import demux16_dispatcher_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic                                io_valid,
  input  logic [LANE_W-1:0]                   io_sel,
  input  logic [DATA_W-1:0]                   io_in,
  output logic [LANE_COUNT-1:0][DATA_W-1:0]   io_out,
  output logic [LANE_COUNT-1:0]               io_out_valid
);

  // Place the payload and a one-hot valid on the selected lane only.
  always_comb begin
    io_out       = '0;
    io_out_valid = '0;
    if (io_valid) begin
      io_out[io_sel]       = io_in;
      io_out_valid[io_sel] = 1'b1;
    end
  end

endmodule

// File: rtl/demux16_dispatcher.sv
// demux16_dispatcher: single-word holding stage that dispatches each accepted
// word to one of 16 lanes (directed or round-robin), dropping words that stall
// longer than TIMEOUT cycles.
module demux16_dispatcher
  import demux16_dispatcher_pkg::*;
#(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  input  logic [DATA_W-1:0] io_in_data,
  input  logic [3:0]        io_in_dest,
  input  logic              io_mode,
  output logic [DATA_W-1:0] io_outputs_0,
  output logic [DATA_W-1:0] io_outputs_1,
  output logic [DATA_W-1:0] io_outputs_2,
  output logic [DATA_W-1:0] io_outputs_3,
  output logic [DATA_W-1:0] io_outputs_4,
  output logic [DATA_W-1:0] io_outputs_5,
  output logic [DATA_W-1:0] io_outputs_6,
  output logic [DATA_W-1:0] io_outputs_7,
  output logic [DATA_W-1:0] io_outputs_8,
  output logic [DATA_W-1:0] io_outputs_9,
  output logic [DATA_W-1:0] io_outputs_10,
  output logic [DATA_W-1:0] io_outputs_11,
  output logic [DATA_W-1:0] io_outputs_12,
  output logic [DATA_W-1:0] io_outputs_13,
  output logic [DATA_W-1:0] io_outputs_14,
  output logic [DATA_W-1:0] io_outputs_15,
  output logic [15:0]       io_out_valid,
  input  logic [15:0]       io_out_ready,
  output logic [15:0]       io_drop_count,
  output logic              io_busy
);

  state_t                            state, state_nxt;
  logic [DATA_W-1:0]                 data_q;
  logic [LANE_W-1:0]                 lane_q;
  logic [LANE_W-1:0]                 rr_q;
  logic [7:0]                        stall_q;
  logic [15:0]                       drop_q;

  logic                              deliver;
  logic                              capture;
  logic                              timeout_hit;
  logic [LANE_W-1:0]                 demux_sel;
  logic [LANE_COUNT-1:0][DATA_W-1:0] lane_data;

  // Handshake decode and next-state selection.
  always_comb begin
    deliver     = (state == HOLD) && io_out_ready[lane_q];
    io_in_ready = !reset && ((state == IDLE) || deliver);
    capture     = io_in_valid && io_in_ready;
    // Drop fires on the edge where the stall count would reach TIMEOUT;
    // a delivery in that same cycle wins.
    timeout_hit = (state == HOLD) && !deliver &&
                  ((9'(stall_q) + 9'd1) == 9'(TIMEOUT));
    state_nxt   = state;
    case (state)
      IDLE: if (capture) state_nxt = HOLD;
      HOLD: begin
        if (deliver)          state_nxt = capture ? HOLD : IDLE;
        else if (timeout_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus holding word, lane, rr pointer, stall and drop counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      data_q  <= '0;
      lane_q  <= '0;
      rr_q    <= '0;
      stall_q <= '0;
      drop_q  <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        data_q  <= io_in_data;
        lane_q  <= io_mode ? rr_q : io_in_dest;
        stall_q <= '0;
        if (io_mode) rr_q <= rr_q + 4'd1;
      end else if ((state == HOLD) && !deliver && !timeout_hit) begin
        stall_q <= stall_q + 8'd1;
      end
      if (timeout_hit && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
    end
  end

  assign demux_sel     = (state == HOLD) ? lane_q : '0;
  assign io_busy       = (state == HOLD);
  assign io_drop_count = drop_q;

  Demultiplexer #(.DATA_W(DATA_W)) u_demux (
    .io_valid     (state == HOLD),
    .io_sel       (demux_sel),
    .io_in        (data_q),
    .io_out       (lane_data),
    .io_out_valid (io_out_valid)
  );

  assign io_outputs_0  = lane_data[0];
  assign io_outputs_1  = lane_data[1];
  assign io_outputs_2  = lane_data[2];
  assign io_outputs_3  = lane_data[3];
  assign io_outputs_4  = lane_data[4];
  assign io_outputs_5  = lane_data[5];
  assign io_outputs_6  = lane_data[6];
  assign io_outputs_7  = lane_data[7];
  assign io_outputs_8  = lane_data[8];
  assign io_outputs_9  = lane_data[9];
  assign io_outputs_10 = lane_data[10];
  assign io_outputs_11 = lane_data[11];
  assign io_outputs_12 = lane_data[12];
  assign io_outputs_13 = lane_data[13];
  assign io_outputs_14 = lane_data[14];
  assign io_outputs_15 = lane_data[15];

endmodule

// File: tb/tb_demux16_dispatcher.sv
// Bench for demux16_dispatcher: directed scenarios plus randomized traffic,
// all checked against a transaction-level model of the holding stage.
module tb_demux16_dispatcher;

  localparam int unsigned TO = 8;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [3:0]  in_dest;
  logic        mode;
  logic [63:0] outs [16];
  logic [15:0] out_valid;
  logic [15:0] out_ready;
  logic [15:0] drop_count;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Model: "is a word waiting, which one, where to, how long has it waited".
  bit          m_full;
  logic [63:0] m_data;
  int unsigned m_lane;
  int unsigned m_age;
  int unsigned m_rr;
  int unsigned m_drops;

  // Lane-7 valid&ready handshakes seen while the reset scenario runs.
  bit          watch7;
  int unsigned lane7_hits;

  demux16_dispatcher #(.DATA_W(64), .TIMEOUT(TO)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (in_valid),
    .io_in_ready  (in_ready),
    .io_in_data   (in_data),
    .io_in_dest   (in_dest),
    .io_mode      (mode),
    .io_outputs_0 (outs[0]),
    .io_outputs_1 (outs[1]),
    .io_outputs_2 (outs[2]),
    .io_outputs_3 (outs[3]),
    .io_outputs_4 (outs[4]),
    .io_outputs_5 (outs[5]),
    .io_outputs_6 (outs[6]),
    .io_outputs_7 (outs[7]),
    .io_outputs_8 (outs[8]),
    .io_outputs_9 (outs[9]),
    .io_outputs_10(outs[10]),
    .io_outputs_11(outs[11]),
    .io_outputs_12(outs[12]),
    .io_outputs_13(outs[13]),
    .io_outputs_14(outs[14]),
    .io_outputs_15(outs[15]),
    .io_out_valid (out_valid),
    .io_out_ready (out_ready),
    .io_drop_count(drop_count),
    .io_busy      (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) begin
    if (watch7 && out_valid[7] && out_ready[7]) lane7_hits <= lane7_hits + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // One cycle: drive inputs, compare outputs against the model, advance both.
  task automatic step(input logic r, input logic v, input logic m, input logic [3:0] d,
                      input logic [63:0] dat, input logic [15:0] rdy);
    bit          exp_ready;
    bit          acc;
    bit          deliv;
    logic [15:0] exp_valid;
    logic [63:0] exp_lane;
    reset = r; in_valid = v; mode = m; in_dest = d; in_data = dat; out_ready = rdy;
    #1;
    exp_ready = !r && (!m_full || rdy[m_lane]);
    exp_valid = m_full ? (16'd1 << m_lane) : 16'd0;
    check_eq("in_ready", 64'(in_ready), 64'(exp_ready));
    check_eq("busy", 64'(busy), 64'(m_full));
    check_eq("out_valid", 64'(out_valid), 64'(exp_valid));
    check_eq("drop_count", 64'(drop_count), 64'(m_drops));
    for (int i = 0; i < 16; i++) begin
      exp_lane = (m_full && m_lane == i) ? m_data : 64'd0;
      check_eq($sformatf("lane%0d", i), outs[i], exp_lane);
    end
    acc   = v && exp_ready;
    deliv = m_full && rdy[m_lane];
    @(posedge clock);
    if (r) begin
      m_full = 0; m_rr = 0; m_age = 0; m_drops = 0;
    end else begin
      if (deliv) m_full = 0;
      else if (m_full) begin
        m_age++;
        if (m_age == TO) begin
          m_full = 0;
          if (m_drops < 65535) m_drops++;
        end
      end
      if (acc) begin
        m_full = 1; m_data = dat; m_age = 0;
        m_lane = m ? m_rr : 32'(d);
        if (m) m_rr = (m_rr + 1) % 16;
      end
    end
    @(negedge clock);
  endtask

  task automatic idle(input logic [15:0] rdy);
    step(0, 0, 0, 4'd0, 64'd0, rdy);
  endtask

  initial begin
    int unsigned regime;
    logic [15:0] rdy;
    watch7 = 0; lane7_hits = 0;
    m_full = 0; m_data = '0; m_lane = 0; m_age = 0; m_rr = 0; m_drops = 0;
    reset = 1; in_valid = 0; mode = 0; in_dest = 0; in_data = 0; out_ready = 0;
    // Unchecked first reset edge brings the DUT out of its unknown power-up state.
    @(posedge clock);
    @(negedge clock);
    step(1, 0, 0, 4'd0, 64'd0, 16'hFFFF);
    idle(16'hFFFF);

    // Directed word to lane 5.
    step(0, 1, 0, 4'd5, 64'hDEAD_BEEF, 16'hFFFF);
    #1;
    check_eq("dir_lane5", outs[5], 64'hDEAD_BEEF);
    check_eq("dir_valid", 64'(out_valid), 64'h0020);
    idle(16'hFFFF);
    check_eq("dir_idle", 64'(busy), 64'd0);

    // Back-to-back round-robin from a fresh pointer.
    step(1, 0, 0, 4'd0, 64'd0, 16'hFFFF);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 4'd9, 64'h100 + 64'(i), 16'hFFFF);
    idle(16'hFFFF);
    idle(16'hFFFF);

    // Seventeen round-robin words wrap back to lane 0.
    step(1, 0, 0, 4'd0, 64'd0, 16'hFFFF);
    for (int i = 0; i < 17; i++) step(0, 1, 1, 4'd2, 64'hA000 + 64'(i), 16'hFFFF);
    check_eq("wrap_lane0", 64'(out_valid), 64'h0001);
    idle(16'hFFFF);

    // Timeout drop on lane 3.
    step(1, 0, 0, 4'd0, 64'd0, 16'hFFFF);
    step(0, 1, 0, 4'd3, 64'h3333, 16'hFFF7);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 4'd1, 64'h44, 16'hFFF7);
    check_eq("to_drop", 64'(drop_count), 64'd1);
    check_eq("to_idle", 64'(busy), 64'd0);
    idle(16'hFFFF);

    // Ready arrives on the would-be timeout cycle: delivered, no drop.
    step(1, 0, 0, 4'd0, 64'd0, 16'hFFFF);
    step(0, 1, 0, 4'd3, 64'h5555, 16'hFFF7);
    for (int i = 0; i < 7; i++) idle(16'hFFF7);
    idle(16'hFFFF);
    check_eq("late_ready_drop", 64'(drop_count), 64'd0);
    check_eq("late_ready_idle", 64'(busy), 64'd0);

    // Reset while a word waits on lane 7.
    watch7 = 1;
    step(0, 1, 0, 4'd7, 64'h7777, 16'h0000);
    idle(16'h0000);
    step(1, 0, 0, 4'd0, 64'd0, 16'h0000);
    idle(16'hFFFF);
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_drops", 64'(drop_count), 64'd0);
    step(0, 1, 1, 4'd7, 64'h8888, 16'hFFFF);
    check_eq("rst_rr0", 64'(out_valid), 64'h0001);
    idle(16'hFFFF);
    watch7 = 0;
    check_eq("lane7_never", 64'(lane7_hits), 64'd0);

    // Randomized traffic with shifting backpressure regimes.
    regime = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 0) regime = $urandom_range(0, 2);
      case (regime)
        0:       rdy = 16'hFFFF;
        1:       rdy = 16'($urandom);
        default: rdy = 16'($urandom & $urandom & $urandom);
      endcase
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
           4'($urandom), {$urandom, $urandom}, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
